discrete_sample_sink: RTL and testbench
=======================================

DISCRETE_SAMPLE_SINK -- requirements
Module: discrete_sample_sink

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, audio sample rate in Hz; legal only when CLOCK_RATE >= 2*SAMPLE_RATE.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, sample buffer entries; power of two, 2..16.
REQ-004 SHALL have port clk, input, 1, the one system clock; all logic on its rising edge.
REQ-005 SHALL have port I_RSTn, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port audio_clk_en, output, 1, sample-rate strobe that drives all discrete circuit blocks.
REQ-007 SHALL have port in, input, signed 16, sample from the circuit, updated by the producer on audio_clk_en.
REQ-008 SHALL have port out_data, output, signed 16, head sample toward the downstream audio path.
REQ-009 SHALL have port out_valid, output, 1, out_data holds an unconsumed sample.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts out_data this cycle.
REQ-011 SHALL have port overflow, output, 1, sticky flag: a sample was dropped.
REQ-012 SHALL have port overflow_clr, input, 1, clears overflow.

Function
REQ-013 Strobe generator: unsigned phase accumulator acc, width ceil(log2(CLOCK_RATE))+1.
REQ-014 Each cycle: if acc+SAMPLE_RATE >= CLOCK_RATE, then acc <= acc+SAMPLE_RATE-CLOCK_RATE and audio_clk_en <= 1; else acc <= acc+SAMPLE_RATE and audio_clk_en <= 0.
REQ-015 audio_clk_en is a registered signal, high exactly one cycle per pulse, never two cycles in a row.
REQ-016 Over any window of CLOCK_RATE cycles, exactly SAMPLE_RATE pulses occur.
REQ-017 Capture is a two-state machine: IDLE, then ARMED after a cycle with audio_clk_en=1.
REQ-018 In ARMED, the block pushes the value of in (one cycle after the strobe, once the producer register has updated) and returns to IDLE the next cycle.
REQ-019 FIFO: FIFO_DEPTH entries, read/write pointers one bit wider than the index; wrap-around at FIFO_DEPTH.
REQ-020 Handshake: a pop occurs when out_valid && out_ready; out_data/out_valid are registered and show the head entry.
REQ-021 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Latency from the push cycle to out_valid=1 with an empty FIFO: 1 cycle.
REQ-023 Push when full with no pop in the same cycle: drop the new sample, leave contents unchanged, set overflow.
REQ-024 Push and pop in the same cycle when full: both take effect, no overflow.
REQ-025 Push and pop in the same cycle when count==1: out_valid stays 1 and out_data advances to the new sample.
REQ-026 overflow_clr in the same cycle as a new drop: the drop wins, so overflow=1.
REQ-027 Samples pass bit-exact: no scaling, no saturation.

Reset
REQ-028 While I_RSTn=0: acc=0, audio_clk_en=0, capture state IDLE, pointers=0, out_valid=0, out_data=0, overflow=0.
REQ-029 Reset asserted mid-operation discards buffered samples immediately, without waiting for a clock edge.
REQ-030 After release, the first audio_clk_en comes on cycle ceil(CLOCK_RATE/SAMPLE_RATE).

Structure
REQ-031 A shared package SHALL hold the sample typedef (signed 16), and an accumulator-width function.
REQ-032 The FIFO SHALL be one sub-module, sample_fifo (parameter DEPTH), reusable by other sound boards.

Verification
REQ-033 CLOCK_RATE=1000000, SAMPLE_RATE=48000, out_ready=1, run 1000000 cycles -> exactly 48000 strobes; strobe gaps are only 20 or 21 cycles.
REQ-034 in = ramp 0,1,2,... changing one cycle after each strobe, out_ready=1 -> out_data sequence 0,1,2,... with none missing; each sample appears 2 cycles after its strobe.
REQ-035 out_ready=0 for 6 strobes with FIFO_DEPTH=4 -> first 4 samples held, overflow=1 after the 5th; then out_ready=1 -> the 4 oldest drain in order.
REQ-036 in=-32768 and in=32767 -> out_data identical, sign preserved.
REQ-037 FIFO full with out_ready=1 in the push cycle -> no overflow, count unchanged; overflow_clr pulsed on a drop cycle -> overflow stays 1.
REQ-038 I_RSTn pulsed low mid-stream with 3 entries buffered -> out_valid=0 and overflow=0 immediately; next strobe after ceil(CLOCK_RATE/SAMPLE_RATE) cycles.

Source files
------------

// File: rtl/discrete_sample_sink_pkg.sv
// Shared types and helpers for the discrete-circuit sample sink and its FIFO.
package discrete_sample_sink_pkg;

  // One audio sample as produced by the discrete circuit model.
  typedef logic signed [15:0] sample_t;

  // Capture states: wait for a strobe, then take the producer's fresh value.
  typedef enum logic {StIdle, StArmed} cap_state_e;

  // Phase accumulator width: ceil(log2(clock_rate)) + 1.
  function automatic int unsigned acc_width(input int unsigned clock_rate);
    return $clog2(clock_rate) + 1;
  endfunction

endpackage

// File: rtl/discrete_sample_sink_fifo.sv
// sample_fifo: small sample buffer with registered head, ready/valid output
// and a sticky drop flag.
module sample_fifo
  import discrete_sample_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  sample_t push_data,
  output sample_t out_data,
  output logic    out_valid,
  input  logic    out_ready,
  output logic    overflow,
  input  logic    overflow_clr
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  sample_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, count;
  logic          full, pop, do_write, drop, valid_d;
  sample_t       head_d;

  // Pointer arithmetic and the head entry as it will look after this edge.
  always_comb begin
    count    = wr_ptr - rd_ptr;
    full     = (count == PW'(DEPTH));
    pop      = out_valid && out_ready;
    // A pop frees the slot, so a full FIFO still accepts a simultaneous push.
    do_write = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr_ptr + PW'(do_write);
    rd_ptr_d = rd_ptr + PW'(pop);
    valid_d  = (wr_ptr_d != rd_ptr_d);
    // When the new head is the slot being written this edge, bypass memory.
    if (do_write && (rd_ptr_d == wr_ptr)) begin
      head_d = push_data;
    end else begin
      head_d = mem[rd_ptr_d[IW-1:0]];
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[IW-1:0]] <= push_data;
    end
  end

  // Pointers, registered head view and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      out_valid <= valid_d;
      // Hold the last value when empty rather than exposing stale memory.
      if (valid_d) begin
        out_data <= head_d;
      end
      // A new drop outranks a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/discrete_sample_sink.sv
// discrete_sample_sink: generates the audio-rate strobe for the discrete
// circuit blocks, captures each new sample and buffers it for downstream.
module discrete_sample_sink
  import discrete_sample_sink_pkg::*;
#(
  parameter int unsigned CLOCK_RATE  = 1000000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic    clk,
  input  logic    I_RSTn,
  output logic    audio_clk_en,
  input  sample_t in,
  output sample_t out_data,
  output logic    out_valid,
  input  logic    out_ready,
  output logic    overflow,
  input  logic    overflow_clr
);

  localparam int unsigned AW = acc_width(CLOCK_RATE);

  logic [AW-1:0] acc, acc_sum;
  logic          wrap;
  cap_state_e    state;
  logic          push;

  // Next phase; headroom of one bit keeps acc + SAMPLE_RATE from overflowing.
  always_comb begin
    acc_sum = acc + AW'(SAMPLE_RATE);
    wrap    = (acc_sum >= AW'(CLOCK_RATE));
  end

  // Phase accumulator: one registered strobe each time the phase wraps.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      acc          <= '0;
      audio_clk_en <= 1'b0;
    end else if (wrap) begin
      acc          <= acc_sum - AW'(CLOCK_RATE);
      audio_clk_en <= 1'b1;
    end else begin
      acc          <= acc_sum;
      audio_clk_en <= 1'b0;
    end
  end

  // Capture FSM: arm on the strobe, push one cycle later once the producer
  // register has taken its new value.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle:  if (audio_clk_en) state <= StArmed;
        StArmed: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign push = (state == StArmed);

  sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (I_RSTn),
    .push        (push),
    .push_data   (in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

endmodule

// File: tb/tb_discrete_sample_sink.sv
// Directed bench for discrete_sample_sink at default parameters
// (1 MHz clock, 48 kHz strobe, 4-entry FIFO).
module tb_discrete_sample_sink;
  import discrete_sample_sink_pkg::*;

  logic    clk = 1'b0;
  logic    I_RSTn = 1'b0;
  logic    audio_clk_en;
  sample_t in = '0;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready = 1'b1;
  logic    overflow;
  logic    overflow_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  discrete_sample_sink #(
    .CLOCK_RATE (1000000),
    .SAMPLE_RATE(48000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .audio_clk_en(audio_clk_en),
    .in          (in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until the strobe is seen high; bounded.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!audio_clk_en && n < 64);
    if (!audio_clk_en) check("strobe_timeout", 0, 1);
  endtask

  // Producer: update in one cycle after a strobe; optionally pop and/or
  // clear overflow during the push cycle. Returns at the negedge after push.
  task automatic send(input sample_t v, input logic pop_in_push, input logic clr_in_push);
    int   n;
    logic save;
    wait_strobe(n);
    @(posedge clk);
    #1 in = v;
    save = out_ready;
    if (pop_in_push) out_ready = 1'b1;
    if (clr_in_push) overflow_clr = 1'b1;
    @(posedge clk);
    #1 out_ready = save;
    overflow_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", audio_clk_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_overflow", overflow, 0);

    // First strobe lands on cycle ceil(1e6/48000) = 21
    I_RSTn = 1'b1;
    wait_strobe(n);
    check("first_strobe_cycle", n, 21);

    // Gaps are 20 or 21 cycles
    for (int i = 0; i < 4; i++) begin
      wait_strobe(n);
      check("strobe_gap", (n == 20 || n == 21) ? 1 : 0, 1);
    end

    // Pattern repeats every 125 cycles with 6 strobes: 12500 cycles -> 600
    cnt = 0;
    repeat (12500) begin
      @(negedge clk);
      if (audio_clk_en) cnt++;
    end
    check("strobes_per_12500", cnt, 600);

    // Ramp with out_ready=1: each sample visible 2 cycles after its strobe
    for (int k = 0; k < 5; k++) begin
      send(sample_t'(k), 1'b0, 1'b0);
      check("ramp_valid", out_valid, 1);
      check("ramp_data", out_data, k);
      @(negedge clk);
      check("ramp_drained", out_valid, 0);
    end

    // Backpressure: 6 strobes into 4 entries
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(sample_t'(100 + k), 1'b0, 1'b0);
      check("bp_head_stable", out_data, 100);
      check("bp_valid", out_valid, 1);
      check("bp_overflow", overflow, (k >= 4) ? 1 : 0);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("bp_drain_data", out_data, 100 + j);
      check("bp_drain_valid", out_valid, 1);
      @(negedge clk);
    end
    check("bp_drain_empty", out_valid, 0);
    check("bp_overflow_sticky", overflow, 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("overflow_cleared", overflow, 0);

    // Extremes pass bit-exact
    send(sample_t'(-32768), 1'b0, 1'b0);
    check("min_sample", out_data, -32768);
    @(negedge clk);
    send(sample_t'(32767), 1'b0, 1'b0);
    check("max_sample", out_data, 32767);
    @(negedge clk);

    // Full FIFO with pop in the push cycle, then clear on a drop cycle
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(sample_t'(200 + k), 1'b0, 1'b0);
    send(sample_t'(204), 1'b1, 1'b0);
    check("full_pushpop_overflow", overflow, 0);
    check("full_pushpop_head", out_data, 201);
    send(sample_t'(205), 1'b0, 1'b1);
    check("drop_beats_clr", overflow, 1);
    check("drop_head", out_data, 201);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("full_drain_data", out_data, 201 + j);
      check("full_drain_valid", out_valid, 1);
      @(negedge clk);
    end
    check("full_drain_empty", out_valid, 0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;

    // Reset mid-stream with 3 entries buffered acts before any clock edge
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(sample_t'(300 + k), 1'b0, 1'b0);
    check("pre_reset_head", out_data, 300);
    #2 I_RSTn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_data", out_data, 0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    I_RSTn = 1'b1;
    wait_strobe(n);
    check("restart_strobe_cycle", n, 21);
    check("restart_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
